// File: rtl/fifo_stream_pkg.sv
// Shared types and constants for the FIFO read-side stream adapter.
package fifo_stream_pkg;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        TWO   = 2'd2
    } occ_t;

    localparam int BCNT_W_DEFAULT = 16;

endpackage

// File: rtl/fifo_stream_out.sv
// FWFT FIFO read port to registered valid/ready stream via a two-entry main/skid buffer.
// Optional accepted-beat counter enabled by defining FIFO_STREAM_BEATCNT_EN.
module fifo_stream_out
    import fifo_stream_pkg::*;
#(
    parameter int DATA_W = 4
`ifdef FIFO_STREAM_BEATCNT_EN
    ,
    parameter int BCNT_W = BCNT_W_DEFAULT
`endif
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_fifo_empty,
    input  logic [DATA_W-1:0] i_fifo_rddata,
    output logic              o_fifo_rden,
    output logic [DATA_W-1:0] o_m_data,
    output logic              o_m_valid,
    input  logic              i_m_ready
`ifdef FIFO_STREAM_BEATCNT_EN
    ,
    output logic [BCNT_W-1:0] o_beatcnt
`endif
);

    occ_t              occ_q, occ_d;
    logic [DATA_W-1:0] main_q, main_d;
    logic [DATA_W-1:0] skid_q, skid_d;
    logic              pop;
    logic              drain;

    // Pop decision uses only registered occupancy and the empty flag, so ready never reaches rden.
    // Popping is held off during reset since any captured word would be discarded anyway.
    always_comb begin
        pop       = !rst && !i_fifo_empty && ((occ_q == EMPTY) || (occ_q == ONE));
        o_m_valid = (occ_q == ONE) || (occ_q == TWO);
        drain     = o_m_valid && i_m_ready;
    end

    assign o_fifo_rden = pop;
    assign o_m_data    = main_q;

    always_comb begin
        occ_d  = occ_q;
        main_d = main_q;
        skid_d = skid_q;
        case (occ_q)
            EMPTY: begin
                if (pop) begin
                    main_d = i_fifo_rddata;
                    occ_d  = ONE;
                end
            end
            ONE: begin
                if (pop && drain) begin
                    main_d = i_fifo_rddata;
                end else if (pop) begin
                    skid_d = i_fifo_rddata;
                    occ_d  = TWO;
                end else if (drain) begin
                    occ_d = EMPTY;
                end
            end
            TWO: begin
                if (drain) begin
                    main_d = skid_q;
                    occ_d  = ONE;
                end
            end
            default: occ_d = EMPTY;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            occ_q  <= EMPTY;
            main_q <= '0;
        end else begin
            occ_q  <= occ_d;
            main_q <= main_d;
        end
    end

    // Skid contents are only meaningful in TWO, so they need no reset.
    always_ff @(posedge clk) begin
        skid_q <= skid_d;
    end

`ifdef FIFO_STREAM_BEATCNT_EN
    logic [BCNT_W-1:0] beatcnt_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            beatcnt_q <= '0;
        end else if (drain) begin
            beatcnt_q <= beatcnt_q + 1'b1;
        end
    end

    assign o_beatcnt = beatcnt_q;
`endif

endmodule

// File: tb/tb_fifo_stream_out.sv
// Self-checking bench for fifo_stream_out: FIFO and output buffer modelled as queues.
module tb_fifo_stream_out;

    localparam int DATA_W = 4;
`ifdef FIFO_STREAM_BEATCNT_EN
    localparam int BCNT_W = 4;
`endif

    logic              clk = 1'b0;
    logic              rst;
    logic              i_fifo_empty;
    logic [DATA_W-1:0] i_fifo_rddata;
    logic              o_fifo_rden;
    logic [DATA_W-1:0] o_m_data;
    logic              o_m_valid;
    logic              i_m_ready;
`ifdef FIFO_STREAM_BEATCNT_EN
    logic [BCNT_W-1:0] o_beatcnt;
`endif

    always #5 clk = ~clk;

    fifo_stream_out #(
        .DATA_W(DATA_W)
`ifdef FIFO_STREAM_BEATCNT_EN
        ,
        .BCNT_W(BCNT_W)
`endif
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .i_fifo_empty (i_fifo_empty),
        .i_fifo_rddata(i_fifo_rddata),
        .o_fifo_rden  (o_fifo_rden),
        .o_m_data     (o_m_data),
        .o_m_valid    (o_m_valid),
        .i_m_ready    (i_m_ready)
`ifdef FIFO_STREAM_BEATCNT_EN
        ,
        .o_beatcnt    (o_beatcnt)
`endif
    );

    int checks = 0;
    int errors = 0;

    logic [DATA_W-1:0] fifo_q[$];   // words waiting in the upstream FIFO
    logic [DATA_W-1:0] buf_q[$];    // words held by the adapter, oldest first
    int beats = 0;                  // accepted beats since last reset
    int pops = 0;
    int emitted = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One clock: drive at negedge, check, then apply the reference model at posedge.
    task automatic step(input logic rdy, input logic r, input logic xe);
        logic exp_valid, exp_rden, drain;
        i_m_ready     = rdy;
        rst           = r;
        i_fifo_empty  = (fifo_q.size() == 0) || xe;
        i_fifo_rddata = (fifo_q.size() != 0) ? fifo_q[0] : '0;
        #1;
        exp_valid = (buf_q.size() != 0);
        exp_rden  = !r && !i_fifo_empty && (buf_q.size() < 2);
        chk("valid", {31'd0, o_m_valid}, {31'd0, exp_valid});
        chk("rden", {31'd0, o_fifo_rden}, {31'd0, exp_rden});
        if (exp_valid) chk("data", {28'd0, o_m_data}, {28'd0, buf_q[0]});
`ifdef FIFO_STREAM_BEATCNT_EN
        chk("beatcnt", {28'd0, o_beatcnt}, beats % (1 << BCNT_W));
`endif
        drain = exp_valid && rdy;
        @(posedge clk);
        if (r) begin
            buf_q.delete();
            beats = 0;
        end else begin
            if (drain) begin
                void'(buf_q.pop_front());
                beats++;
                emitted++;
            end
            if (exp_rden) begin
                buf_q.push_back(fifo_q.pop_front());
                pops++;
            end
        end
        @(negedge clk);
    endtask

    task automatic drain_all(input int budget);
        int n = 0;
        while ((buf_q.size() != 0 || fifo_q.size() != 0) && n < budget) begin
            step(1'b1, 1'b0, 1'b0);
            n++;
        end
        chk("drain_budget", {31'd0, (n < budget)}, 32'd1);
    endtask

    initial begin
        rst = 1'b1;
        i_m_ready = 1'b0;
        i_fifo_empty = 1'b1;
        i_fifo_rddata = '0;
        @(posedge clk);
        @(negedge clk);

        // Reset state
        step(1'b0, 1'b1, 1'b0);
        chk("reset_data", {28'd0, o_m_data}, 32'd0);
        chk("reset_valid", {31'd0, o_m_valid}, 32'd0);
`ifdef FIFO_STREAM_BEATCNT_EN
        chk("reset_beatcnt", {28'd0, o_beatcnt}, 32'd0);
`endif

        // Three words with ready high
        emitted = 0;
        fifo_q.push_back(4'h1); fifo_q.push_back(4'h2); fifo_q.push_back(4'h3);
        for (int i = 0; i < 6; i++) step(1'b1, 1'b0, 1'b0);
        chk("three_emitted", emitted, 3);
`ifdef FIFO_STREAM_BEATCNT_EN
        chk("three_beatcnt", {28'd0, o_beatcnt}, 32'd3);
`endif

        // Backpressure with A..D preloaded
        pops = 0; emitted = 0;
        fifo_q.push_back(4'hA); fifo_q.push_back(4'hB);
        fifo_q.push_back(4'hC); fifo_q.push_back(4'hD);
        for (int i = 0; i < 5; i++) step(1'b0, 1'b0, 1'b0);
        chk("bp_pops", pops, 2);
        chk("bp_hold", {28'd0, o_m_data}, 32'hA);
        for (int i = 0; i < 4; i++) step(1'b1, 1'b0, 1'b0);
        chk("bp_back_to_back", emitted, 4);

        // Ready toggling 1010 with one write per cycle, 64 random words
        emitted = 0;
        for (int i = 0; i < 64; i++) begin
            fifo_q.push_back(DATA_W'($urandom_range(0, 15)));
            step(((i % 2) == 0), 1'b0, 1'b0);
        end
        drain_all(200);
        chk("toggle_count", emitted, 64);

        // Random writes and random ready
        emitted = 0;
        for (int i = 0; i < 300; i++) begin
            if ($urandom_range(0, 2) != 0) fifo_q.push_back(DATA_W'($urandom));
            step(1'($urandom_range(0, 1)), 1'b0, 1'b0);
        end
        drain_all(400);

        // Extended-empty pulse on a write into the empty FIFO
        emitted = 0;
        fifo_q.push_back(4'h7);
        step(1'b1, 1'b0, 1'b1);
        step(1'b1, 1'b0, 1'b0);
        step(1'b1, 1'b0, 1'b0);
        step(1'b1, 1'b0, 1'b0);
        chk("xe_once", emitted, 1);

        // Reset while both 0x5 and 0x6 are buffered
        fifo_q.push_back(4'h5); fifo_q.push_back(4'h6);
        for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 1'b0);
        chk("two_buffered", buf_q.size(), 2);
        step(1'b1, 1'b1, 1'b0);
        step(1'b1, 1'b1, 1'b0);
        chk("rst_two_data", {28'd0, o_m_data}, 32'd0);
        emitted = 0;
        for (int i = 0; i < 4; i++) step(1'b1, 1'b0, 1'b0);
        chk("rst_no_stale", emitted, 0);

        // 17 beats after reset
        emitted = 0;
        for (int i = 0; i < 17; i++) fifo_q.push_back(DATA_W'(i));
        drain_all(40);
        chk("seventeen_beats", emitted, 17);
`ifdef FIFO_STREAM_BEATCNT_EN
        chk("beatcnt_wrap", {28'd0, o_beatcnt}, 32'd1);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
